// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: block type, round-constant table,
// default round count and the key expander state encoding.
package aes_pkg;

  localparam int NUM_ROUNDS_DEF = 10;

  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ks_state_e;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant used when stepping from round key idx to idx+1.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/key_expander_if.sv
// Consumer-facing port bundle of the key expander; slave is the expander side.
interface key_expander_if;
  import aes_pkg::*;

  // key_valid/key_ready: a round key transfers on every clk edge where both
  // are high; while key_valid is high and key_ready low, round_key and
  // round_idx stay stable and key_valid stays high until the transfer.
  block_t      key_in;
  logic        start;
  logic        key_ready;
  block_t      round_key;
  logic        key_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;
  ks_state_e   dbg_state;

  modport master (
    output key_in, start, key_ready,
    input  round_key, key_valid, round_idx, busy, done, dbg_state
  );

  modport slave (
    input  key_in, start, key_ready,
    output round_key, key_valid, round_idx, busy, done, dbg_state
  );

endinterface

// File: rtl/ks_sbox.sv
// Combinational AES forward S-box: one byte in, one byte out.
module ks_sbox (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);

  // Entry for input i lives at bits [2047-8*i -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;

  assign w_base = {i_data, 3'b000};
  assign o_data = SBOX[11'd2047 - w_base -: 8];

endmodule

// File: rtl/key_expander.sv
// Iterative AES-128 key schedule: latches a cipher key on start and streams
// round keys 0..NUM_ROUNDS, deriving each next key from the held one.
module key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input logic           clk,
  input logic           rst_an,
  key_expander_if.slave ks
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e   r_state;
  block_t      r_key;
  logic [3:0]  r_idx;
  logic        r_valid;
  logic        r_done;

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  block_t      w_next;
  logic        w_hs;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    ks_sbox u_sbox (
      .i_data (w_rot[8*g +: 8]),
      .o_data (w_sub[8*g +: 8])
    );
  end

  assign w_t    = w_sub ^ {rcon_of(r_idx), 24'h000000};
  assign w_n0   = w_w0 ^ w_t;
  assign w_n1   = w_w1 ^ w_n0;
  assign w_n2   = w_w2 ^ w_n1;
  assign w_n3   = w_w3 ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};
  assign w_hs   = r_valid & ks.key_ready;

  always_ff @(posedge clk) begin
    if (rst_an) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ks.start) begin
            r_key   <= ks.key_in;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              // Last key stays on round_key after the sequence ends.
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_key <= w_next;
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ks.round_key = r_key;
  assign ks.round_idx = r_idx;
  assign ks.key_valid = r_valid;
  assign ks.done      = r_done;
  assign ks.busy      = (r_state == ACTIVE);
  assign ks.dbg_state = r_state;

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: FIPS-197 vectors, back-pressure, start-while-active,
// mid-sequence reset, back-to-back restart, random keys and an S-box sweep.
module tb_key_expander;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_an;
  always #5 clk = ~clk;

  key_expander_if ks_if ();

  key_expander u_dut (
    .clk    (clk),
    .rst_an (rst_an),
    .ks     (ks_if.slave)
  );

  logic [7:0] sbox_in, sbox_out;
  ks_sbox u_sbox_chk (
    .i_data (sbox_in),
    .o_data (sbox_out)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [131:0] exp_q[$];
  logic [127:0] model_keys [0:10];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic void expand_key(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = k;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_ref(tmp[31:24]), sbox_ref(tmp[23:16]),
               sbox_ref(tmp[15:8]), sbox_ref(tmp[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++)
      model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind 1: FIPS-197 published keys, kind 2: all-zero key published key 1
  task automatic push_keys(input logic [127:0] k, input int kind);
    expand_key(k);
    if (kind == 1) begin
      model_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      model_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      model_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    end else if (kind == 2) begin
      model_keys[1]  = 128'h62636363626363636263636362636363;
    end
    for (int i = 0; i <= 10; i++) exp_q.push_back({4'(i), model_keys[i]});
  endtask

  always @(negedge clk) begin
    if (!rst_an && ks_if.key_valid && ks_if.key_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_key", {ks_if.round_idx, ks_if.round_key}, '1);
      end else begin
        chk("round_key", {ks_if.round_idx, ks_if.round_key}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue_start(input logic [127:0] k, input int kind);
    @(posedge clk); #1;
    ks_if.start  = 1'b1;
    ks_if.key_in = k;
    push_keys(k, kind);
    @(posedge clk); #1;
    ks_if.start  = 1'b0;
  endtask

  // Cycle c=1 is the first cycle after the start edge; caller is at posedge+1.
  task automatic run_seq(input int exp_done, input int stall_from, input int stall_len,
                         input int pulse_at, input int rst_at, input bit chain_en,
                         input logic [127:0] chain_key, input bit rand_ready);
    int hs = 0;
    int calc_done = 0;
    bit seen = 0;
    for (int c = 1; c <= 200; c++) begin
      if (rand_ready) ks_if.key_ready = ($urandom_range(0, 2) != 0);
      else ks_if.key_ready = !(c >= stall_from && c < stall_from + stall_len);
      ks_if.start = (c == pulse_at);
      if (c == pulse_at) ks_if.key_in = {$urandom, $urandom, $urandom, $urandom};
      if (c == rst_at) begin
        rst_an = 1'b1;
        ks_if.key_ready = 1'b0;
      end
      if (chain_en && c == exp_done) begin
        ks_if.start  = 1'b1;
        ks_if.key_in = chain_key;
        push_keys(chain_key, 2);
      end
      if (ks_if.key_ready && hs < 11) begin
        hs++;
        if (hs == 11) calc_done = c + 1;
      end
      @(negedge clk);
      if (c == 1) chk("busy_active", 132'(ks_if.busy), 132'd1);
      if (!rand_ready && c >= stall_from && c < stall_from + stall_len)
        chk("stall_hold", {ks_if.round_idx, ks_if.round_key},
            {4'(stall_from - 1), model_keys[stall_from - 1]});
      if (c == rst_at) begin
        @(posedge clk); #1;
        rst_an = 1'b0;
        ks_if.key_ready = 1'b1;
        @(negedge clk);
        chk("rst_key_valid", 132'(ks_if.key_valid), 132'd0);
        chk("rst_busy", 132'(ks_if.busy), 132'd0);
        chk("rst_round_idx", 132'(ks_if.round_idx), 132'd0);
        chk("rst_round_key", 132'(ks_if.round_key), 132'd0);
        chk("rst_pending_keys", 132'(exp_q.size()), 132'(11 - (rst_at - 1)));
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
          chk("rst_no_done", 132'(ks_if.done), 132'd0);
          @(negedge clk);
        end
        return;
      end
      if (ks_if.done) begin
        chk("done_cycle", 132'(c), 132'((exp_done != 0) ? exp_done : calc_done));
        chk("done_busy", 132'(ks_if.busy), 132'd0);
        chk("done_valid", 132'(ks_if.key_valid), 132'd0);
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) chk("done_timeout", 132'd0, 132'd1);
    if (chain_en) begin
      @(posedge clk); #1;
      ks_if.start = 1'b0;
    end
  endtask

  // ---------------- test sequence ----------------
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    rst_an          = 1'b1;
    ks_if.start     = 1'b0;
    ks_if.key_ready = 1'b0;
    ks_if.key_in    = '0;
    sbox_in         = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_an = 1'b0;
    @(negedge clk);
    chk("reset_round_key", 132'(ks_if.round_key), 132'd0);
    chk("reset_round_idx", 132'(ks_if.round_idx), 132'd0);
    chk("reset_key_valid", 132'(ks_if.key_valid), 132'd0);
    chk("reset_busy", 132'(ks_if.busy), 132'd0);
    chk("reset_done", 132'(ks_if.done), 132'd0);

    for (int i = 0; i < 256; i++) begin
      sbox_in = 8'(i);
      #1;
      chk("sbox", 132'(sbox_out), 132'(sbox_ref(8'(i))));
    end

    issue_start(FIPS_KEY, 1);
    run_seq(12, 0, 0, 0, 0, 1'b0, '0, 1'b0);

    issue_start(FIPS_KEY, 1);
    run_seq(15, 5, 3, 0, 0, 1'b0, '0, 1'b0);

    issue_start(FIPS_KEY, 1);
    run_seq(12, 0, 0, 6, 0, 1'b0, '0, 1'b0);

    issue_start({$urandom, $urandom, $urandom, $urandom}, 0);
    run_seq(0, 0, 0, 0, 7, 1'b0, '0, 1'b0);

    issue_start({$urandom, $urandom, $urandom, $urandom}, 0);
    run_seq(12, 0, 0, 0, 0, 1'b1, 128'h0, 1'b0);
    run_seq(12, 0, 0, 0, 0, 1'b0, '0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      issue_start({$urandom, $urandom, $urandom, $urandom}, 0);
      run_seq(0, 0, 0, 0, 0, 1'b0, '0, 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 132'(exp_q.size()), 132'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
